// File: rtl/simmem_release_sched.sv
// Release scheduler for one response bank: one countdown timer per slot, then release_en held until final release.
// Optional SIMMEM_SCHED_STATS_EN adds stats_rel_cnt_o, a count of completed slot releases.
module simmem_release_sched #(
  parameter int unsigned NumSlots = 16,
  parameter int unsigned DelayW   = 8,
  parameter int unsigned IidW     = $clog2(NumSlots)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sched_valid_i,
  output logic                sched_ready_o,
  input  logic [IidW-1:0]     sched_iid_i,
  input  logic [DelayW-1:0]   sched_delay_i,
  input  logic                freeze_i,
  output logic [NumSlots-1:0] release_en_o,
  input  logic [NumSlots-1:0] released_addr_onehot_i,
  input  logic                released_last_i,
  output logic [NumSlots-1:0] pending_o,
`ifdef SIMMEM_SCHED_STATS_EN
  output logic [31:0]         stats_rel_cnt_o,
`endif
  output logic                err_o
);

  localparam int unsigned PopW = $clog2(NumSlots + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ARMED = 2'd2
  } slot_state_e;

  slot_state_e         state_q   [NumSlots];
  logic [DelayW-1:0]   cnt_q     [NumSlots];
  slot_state_e         nxt_state [NumSlots];
  logic [DelayW-1:0]   nxt_cnt   [NumSlots];
  logic [NumSlots-1:0] armed_c;
  logic [NumSlots-1:0] nxt_armed;
  logic [NumSlots-1:0] nxt_busy;
  logic                accept_c;
  logic                err_set_c;

  // Ready reflects the current state only, so a slot freed this cycle is not re-accepted until the next
  always_comb begin
    sched_ready_o = 1'b0;
    for (int unsigned k = 0; k < NumSlots; k++) begin
      if (sched_iid_i == IidW'(k)) begin
        sched_ready_o = (state_q[k] == S_IDLE);
      end
    end
  end

  assign accept_c = sched_valid_i && sched_ready_o;

  // Per-slot next state; freeze only holds COUNT slots
  always_comb begin
    for (int unsigned k = 0; k < NumSlots; k++) begin
      nxt_state[k] = state_q[k];
      nxt_cnt[k]   = cnt_q[k];
      armed_c[k]   = (state_q[k] == S_ARMED);
      unique case (state_q[k])
        S_IDLE: begin
          if (accept_c && (sched_iid_i == IidW'(k))) begin
            if (sched_delay_i == '0) begin
              nxt_state[k] = S_ARMED;
            end else begin
              nxt_state[k] = S_COUNT;
              nxt_cnt[k]   = sched_delay_i - DelayW'(1);
            end
          end
        end
        S_COUNT: begin
          if (!freeze_i) begin
            if (cnt_q[k] == '0) begin
              nxt_state[k] = S_ARMED;
            end else begin
              nxt_cnt[k] = cnt_q[k] - DelayW'(1);
            end
          end
        end
        S_ARMED: begin
          if (released_addr_onehot_i[k] && released_last_i) begin
            nxt_state[k] = S_IDLE;
          end
        end
        default: begin
          nxt_state[k] = S_IDLE;
          nxt_cnt[k]   = '0;
        end
      endcase
      nxt_armed[k] = (nxt_state[k] == S_ARMED);
      nxt_busy[k]  = (nxt_state[k] == S_ARMED) || (nxt_state[k] == S_COUNT);
    end
  end

  // Any beat on a slot that is not ARMED is a protocol error
  assign err_set_c = |(released_addr_onehot_i & ~armed_c);

`ifdef SIMMEM_SCHED_STATS_EN
  logic [NumSlots-1:0] rel_done_c;
  logic [PopW-1:0]     rel_pop_c;

  always_comb begin
    rel_done_c = released_last_i ? (released_addr_onehot_i & armed_c) : '0;
    rel_pop_c  = '0;
    for (int unsigned k = 0; k < NumSlots; k++) begin
      rel_pop_c = rel_pop_c + PopW'(rel_done_c[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stats_rel_cnt_o <= '0;
    end else begin
      stats_rel_cnt_o <= stats_rel_cnt_o + 32'(rel_pop_c);
    end
  end
`else
  logic unused_popw;
  assign unused_popw = (PopW == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NumSlots; k++) begin
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
      end
      release_en_o <= '0;
      pending_o    <= '0;
      err_o        <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NumSlots; k++) begin
        state_q[k] <= nxt_state[k];
        cnt_q[k]   <= nxt_cnt[k];
      end
      release_en_o <= nxt_armed;
      pending_o    <= nxt_busy;
      if (err_set_c) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule
